// File: rtl/serial_rx_unstripe_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_rx_unstripe_if
// Description : Serial input and lane outputs of the unstriping receiver.
// Revision    : 1.0
// ============================================================================
interface serial_rx_unstripe_if #(
  parameter int WIDTH = 8,
  parameter int LANES = 4
);
  logic                     serial_in;
  logic                     locked;
  logic [LANES*WIDTH-1:0]   data_out;
  logic [LANES-1:0]         valid_out;

  modport master (
    output serial_in,
    input  locked,
    input  data_out,
    input  valid_out
  );

  modport slave (
    input  serial_in,
    output locked,
    output data_out,
    output valid_out
  );
endinterface
`default_nettype wire

// File: rtl/serial_rx_unstripe.sv
`default_nettype none
// ============================================================================
// Module      : serial_rx_unstripe
// Description : Comma-aligned serial deserialiser that unstripes data bytes
//               round-robin across LANES outputs, with loss-of-lock on gaps.
// Revision    : 1.0
// ============================================================================
module serial_rx_unstripe #(
  parameter int               WIDTH      = 8,
  parameter int               LANES      = 4,
  parameter logic [WIDTH-1:0] COM        = 8'hBC,
  parameter int               LOCK_COUNT = 4,
  parameter int               MAX_GAP    = 64
) (
  input  logic                 clk_32f,
  input  logic                 rst,
  serial_rx_unstripe_if.slave  bus
);

  localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CCW = $clog2(LOCK_COUNT + 1);
  localparam int GCW = $clog2(MAX_GAP + 1);
  localparam int LPW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t                        state_q, state_d;
  logic [WIDTH-2:0]              sh_q, sh_d;
  logic [BCW-1:0]                bit_cnt_q, bit_cnt_d;
  logic [CCW-1:0]                com_cnt_q, com_cnt_d;
  logic [GCW-1:0]                gap_cnt_q, gap_cnt_d;
  logic [LPW-1:0]                lane_ptr_q, lane_ptr_d;
  logic [LANES-1:0][WIDTH-1:0]   data_q, data_d;
  logic [LANES-1:0]              valid_q, valid_d;

  logic [WIDTH-1:0]              sh_next;
  logic                          at_boundary;
  logic                          is_com;

  always_comb begin
    sh_next     = {sh_q, bus.serial_in};
    at_boundary = (bit_cnt_q == BCW'(WIDTH - 1));
    is_com      = (sh_next == COM);

    state_d    = state_q;
    sh_d       = sh_next[WIDTH-2:0];
    bit_cnt_d  = at_boundary ? '0 : bit_cnt_q + BCW'(1);
    com_cnt_d  = com_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    lane_ptr_d = lane_ptr_q;
    data_d     = data_q;
    valid_d    = '0;

    case (state_q)
      SEARCH: begin
        // Bit-level hunt: the first COM found defines the byte boundary.
        bit_cnt_d = '0;
        if (is_com) begin
          com_cnt_d  = CCW'(1);
          lane_ptr_d = '0;
          gap_cnt_d  = '0;
          state_d    = (LOCK_COUNT == 1) ? ACTIVE : ALIGN;
        end
      end
      ALIGN: begin
        if (at_boundary) begin
          if (is_com) begin
            com_cnt_d = com_cnt_q + CCW'(1);
            if (com_cnt_d == CCW'(LOCK_COUNT)) begin
              state_d    = ACTIVE;
              lane_ptr_d = '0;
              gap_cnt_d  = '0;
            end
          end else begin
            state_d   = SEARCH;
            com_cnt_d = '0;
          end
        end
      end
      ACTIVE: begin
        if (at_boundary) begin
          if (is_com) begin
            lane_ptr_d = '0;
            gap_cnt_d  = '0;
          end else begin
            data_d[lane_ptr_q]  = sh_next;
            valid_d[lane_ptr_q] = 1'b1;
            lane_ptr_d = (lane_ptr_q == LPW'(LANES - 1)) ? '0 : lane_ptr_q + LPW'(1);
            gap_cnt_d  = gap_cnt_q + GCW'(1);
            // Too long without an idle symbol: drop lock after forwarding.
            if (gap_cnt_d == GCW'(MAX_GAP)) begin
              state_d    = SEARCH;
              bit_cnt_d  = '0;
              com_cnt_d  = '0;
              gap_cnt_d  = '0;
              lane_ptr_d = '0;
            end
          end
        end
      end
      default: begin
        state_d = SEARCH;
      end
    endcase
  end

  always_ff @(posedge clk_32f) begin
    if (rst) begin
      state_q    <= SEARCH;
      sh_q       <= '0;
      bit_cnt_q  <= '0;
      com_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      lane_ptr_q <= '0;
      data_q     <= '0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      bit_cnt_q  <= bit_cnt_d;
      com_cnt_q  <= com_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      lane_ptr_q <= lane_ptr_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
    end
  end

  assign bus.locked    = (state_q == ACTIVE);
  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_rx_unstripe.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_rx_unstripe
// Description : Scoreboard bench for serial_rx_unstripe with a bit-stream
//               reference model and randomized traffic.
// Revision    : 1.0
// ============================================================================
module tb_serial_rx_unstripe;

  localparam int               WIDTH      = 8;
  localparam int               LANES      = 4;
  localparam logic [WIDTH-1:0] COM        = 8'hBC;
  localparam int               LOCK_COUNT = 4;
  localparam int               MAX_GAP    = 8;

  logic clk_32f = 1'b0;
  logic rst     = 1'b1;

  serial_rx_unstripe_if #(.WIDTH(WIDTH), .LANES(LANES)) bus ();

  serial_rx_unstripe #(
    .WIDTH(WIDTH), .LANES(LANES), .COM(COM),
    .LOCK_COUNT(LOCK_COUNT), .MAX_GAP(MAX_GAP)
  ) dut (
    .clk_32f (clk_32f),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 clk_32f = ~clk_32f;

  typedef struct {
    int               cyc;
    int               lane;
    logic [WIDTH-1:0] data;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Reference model: bit stream view, byte boundaries measured from the COM anchor.
  int               mode   = 0;   // 0 search, 1 counting COMs, 2 locked
  int               ncom   = 0;
  int               anchor = 0;
  int               gap    = 0;
  int               lane   = 0;
  int               window = 0;
  bit               exp_locked = 1'b0;
  logic [WIDTH-1:0] lane_val [LANES];

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  function automatic logic [LANES*WIDTH-1:0] exp_data();
    logic [LANES*WIDTH-1:0] r;
    for (int k = 0; k < LANES; k++) r[k*WIDTH +: WIDTH] = lane_val[k];
    return r;
  endfunction

  function automatic void model_step(bit b, bit r);
    bit   bnd;
    exp_t e;
    if (r) begin
      mode = 0; ncom = 0; gap = 0; lane = 0; window = 0;
      for (int k = 0; k < LANES; k++) lane_val[k] = '0;
      exp_locked = 1'b0;
      return;
    end
    window = ((window << 1) | int'(b)) & ((1 << WIDTH) - 1);
    bnd = (((cyc - anchor) % WIDTH) == 0);
    if (mode == 0) begin
      if (window == int'(COM)) begin
        anchor = cyc; ncom = 1; lane = 0; gap = 0;
        mode = (LOCK_COUNT == 1) ? 2 : 1;
      end
    end else if (mode == 1) begin
      if (bnd) begin
        if (window == int'(COM)) begin
          ncom++;
          if (ncom == LOCK_COUNT) begin mode = 2; lane = 0; gap = 0; end
        end else begin
          mode = 0; ncom = 0;
        end
      end
    end else if (bnd) begin
      if (window == int'(COM)) begin
        lane = 0; gap = 0;
      end else begin
        e.cyc = cyc; e.lane = lane; e.data = window[WIDTH-1:0];
        q.push_back(e);
        lane_val[lane] = window[WIDTH-1:0];
        lane = (lane + 1) % LANES;
        gap++;
        if (gap == MAX_GAP) begin mode = 0; ncom = 0; gap = 0; lane = 0; end
      end
    end
    exp_locked = (mode == 2);
  endfunction

  task automatic drive(bit b, bit r);
    bus.serial_in = b;
    rst = r;
    @(posedge clk_32f);
    cyc++;
    model_step(b, r);
    #1;
  endtask

  task automatic send_byte(logic [WIDTH-1:0] v);
    for (int i = WIDTH - 1; i >= 0; i--) drive(v[i], 1'b0);
  endtask

  task automatic do_reset(int n);
    for (int i = 0; i < n; i++) drive(1'($urandom_range(0, 1)), 1'b1);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a valid pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_32f);
      check("locked", 64'(bus.locked), 64'(exp_locked));
      check("data_out", 64'(bus.data_out), 64'(exp_data()));
      if (bus.valid_out != '0) begin
        check("valid_onehot", 64'($countones(bus.valid_out)), 64'd1);
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_valid at cycle %0d: got valid_out %0h, expected 0", cyc, bus.valid_out);
        end else begin
          e = q.pop_front();
          check("valid_cycle", 64'(cyc), 64'(e.cyc));
          check("valid_lane", 64'(bus.valid_out), 64'(1 << e.lane));
          check("lane_data", 64'(bus.data_out[e.lane*WIDTH +: WIDTH]), 64'(e.data));
        end
      end else if (q.size() != 0 && q[0].cyc <= cyc) begin
        checks++; errors++;
        $display("FAIL missing_valid at cycle %0d: got valid_out 0, expected lane %0d data %0h",
                 cyc, q[0].lane, q[0].data);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, expected end of stimulus");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [WIDTH-1:0] b [8];
    logic [WIDTH-1:0] v;

    bus.serial_in = 1'b0;
    do_reset(2);
    check("reset_locked", 64'(bus.locked), 64'd0);
    check("reset_valid", 64'(bus.valid_out), 64'd0);
    check("reset_data", 64'(bus.data_out), 64'd0);

    // Misaligned lead-in, then lock on four COMs.
    drive(1'b1, 1'b0); drive(1'b0, 1'b0); drive(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) send_byte(COM);
    check("lock_before_4th", 64'(bus.locked), 64'd0);
    send_byte(COM);
    check("lock_after_4th", 64'(bus.locked), 64'd1);

    for (int i = 1; i <= 5; i++) send_byte(WIDTH'(i));
    check("unstripe_lanes", 64'(bus.data_out), 64'h0403_0205);

    send_byte(COM);
    send_byte(8'h11); send_byte(8'h22); send_byte(COM); send_byte(8'h33);
    check("realign_lanes", 64'(bus.data_out), 64'h0403_2233);

    // Failed lock followed by a clean lock.
    do_reset(2);
    send_byte(COM); send_byte(COM); send_byte(8'hAB);
    check("failed_lock", 64'(bus.locked), 64'd0);
    for (int i = 0; i < 4; i++) send_byte(COM);
    check("relock", 64'(bus.locked), 64'd1);

    // MAX_GAP data bytes without an idle symbol drop lock on the last one.
    for (int i = 0; i < 8; i++) begin
      do b[i] = WIDTH'($urandom_range(0, 255)); while (b[i] == COM);
    end
    for (int i = 0; i < 7; i++) send_byte(b[i]);
    check("gap_still_locked", 64'(bus.locked), 64'd1);
    send_byte(b[7]);
    check("gap_lost_lock", 64'(bus.locked), 64'd0);
    check("gap_lanes", 64'(bus.data_out), 64'({b[7], b[6], b[5], b[4]}));

    // Randomized traffic: idles, data and occasional bit slips.
    for (int i = 0; i < 4; i++) send_byte(COM);
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 99) < 8) begin
        for (int k = 0; k < int'($urandom_range(1, 3)); k++) drive(1'($urandom_range(0, 1)), 1'b0);
      end
      if ($urandom_range(0, 99) < 30) v = COM;
      else v = WIDTH'($urandom_range(0, 255));
      send_byte(v);
      if ($urandom_range(0, 99) < 3) for (int k = 0; k < 4; k++) send_byte(COM);
    end

    // Reset in the middle of a byte while locked.
    do_reset(2);
    for (int i = 0; i < 4; i++) send_byte(COM);
    send_byte(8'h5A);
    check("pre_reset_locked", 64'(bus.locked), 64'd1);
    drive(1'b0, 1'b0); drive(1'b1, 1'b1);
    check("midreset_locked", 64'(bus.locked), 64'd0);
    check("midreset_valid", 64'(bus.valid_out), 64'd0);
    check("midreset_data", 64'(bus.data_out), 64'd0);
    for (int i = 0; i < 12; i++) drive(1'($urandom_range(0, 1)), 1'b0);

    @(negedge clk_32f);
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
